bin_centroid: RTL

- Downstream consumer of the binary-mask video stream produced by the YCbCr threshold stage.
- Accumulates the zeroth and first moments of the mask over each frame, then computes the centroid (x, y) with a sequential divider during vertical blanking.
- Re-emits the video with a one-cycle delay and draws a cross-hair marker at the last valid centroid.

---
 rtl/bin_centroid.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/bin_centroid.sv
// Purpose : mask-stream centroid tracker with cross-hair overlay on the re-emitted video.
// Latency : video path 1 cycle; centroid 66 cycles after frame end (1 cycle for an empty frame).
// Backpr. : none, free-running pixel stream; a new frame end aborts any division in flight.
//
// Ports:
//   clk, rst                       pixel clock, synchronous active-high reset
//   de_in, h_sync_in, v_sync_in    mask stream timing (active high)
//   pixel_in                       mask pixel, object bit is pixel_in[0]
//   pixel_out, de_out,
//   h_sync_out, v_sync_out         video delayed by one cycle, marker overlaid
//   x_c, y_c, c_valid              centroid of the last completed frame
module bin_centroid #(
    parameter int          IMG_W      = 1280,
    parameter int          IMG_H      = 720,
    parameter logic [23:0] MARKER_RGB = 24'hFF0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       de_in,
    input  logic                       h_sync_in,
    input  logic                       v_sync_in,
    input  logic [23:0]                pixel_in,
    output logic [23:0]                pixel_out,
    output logic                       de_out,
    output logic                       h_sync_out,
    output logic                       v_sync_out,
    output logic [$clog2(IMG_W)-1:0]   x_c,
    output logic [$clog2(IMG_H)-1:0]   y_c,
    output logic                       c_valid
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DIV_X  = 2'd1;
    localparam logic [1:0] DIV_Y  = 2'd2;
    localparam logic [1:0] UPDATE = 2'd3;

    // video delay line
    logic        de_q, hs_q, vs_q, mark_q;
    logic [23:0] pix_q;

    // position and moments
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic [20:0]   m00;
    logic [31:0]   m10, m01;

    // divider
    logic [1:0]    state;
    logic [5:0]    cnt;
    logic [20:0]   div_s;      // divisor (m00 snapshot)
    logic [31:0]   m01_s;      // dividend for the y pass
    logic          zero_s;     // snapshot had no object pixels
    logic [31:0]   dq;         // dividend shifting out, quotient shifting in
    logic [20:0]   rem;
    logic [XW-1:0] qx;

    logic        vs_rise, de_fall, obj;
    logic [21:0] trial;
    logic        ge;
    logic [20:0] rem_nxt;

    assign vs_rise = v_sync_in & ~vs_q;
    assign de_fall = de_q & ~de_in;
    assign obj     = de_in & pixel_in[0];

    // One restoring step. The remainder stays below the divisor (< 2^21),
    // so the trial value needs only one extra bit.
    always_comb begin
        trial   = {rem, dq[31]};
        ge      = (trial >= {1'b0, div_s});
        rem_nxt = ge ? 21'(trial - {1'b0, div_s}) : trial[20:0];
    end

    assign de_out     = de_q;
    assign h_sync_out = hs_q;
    assign v_sync_out = vs_q;
    assign pixel_out  = (de_q && c_valid && mark_q) ? MARKER_RGB : pix_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            de_q    <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            mark_q  <= 1'b0;
            pix_q   <= '0;
            x_cnt   <= '0;
            y_cnt   <= '0;
            m00     <= '0;
            m10     <= '0;
            m01     <= '0;
            state   <= IDLE;
            cnt     <= '0;
            div_s   <= '0;
            m01_s   <= '0;
            zero_s  <= 1'b0;
            dq      <= '0;
            rem     <= '0;
            qx      <= '0;
            x_c     <= '0;
            y_c     <= '0;
            c_valid <= 1'b0;
        end else begin
            de_q   <= de_in;
            hs_q   <= h_sync_in;
            vs_q   <= v_sync_in;
            pix_q  <= pixel_in;
            mark_q <= (x_cnt == x_c) || (y_cnt == y_c);

            if (de_fall)
                x_cnt <= '0;
            else if (de_in)
                x_cnt <= x_cnt + 1'b1;

            if (vs_rise)
                y_cnt <= '0;
            else if (de_fall)
                y_cnt <= y_cnt + 1'b1;

            // A pixel arriving with the frame-end edge seeds the new frame.
            if (vs_rise) begin
                m00 <= obj ? 21'd1 : 21'd0;
                m10 <= obj ? 32'(x_cnt) : 32'd0;
                m01 <= obj ? 32'(y_cnt) : 32'd0;
            end else if (obj) begin
                m00 <= m00 + 21'd1;
                m10 <= m10 + 32'(x_cnt);
                m01 <= m01 + 32'(y_cnt);
            end

            // UPDATE reads the pre-edge operands, so it still completes even
            // if a new frame end lands in the same cycle.
            if (state == UPDATE) begin
                if (zero_s) begin
                    x_c     <= '0;
                    y_c     <= '0;
                    c_valid <= 1'b0;
                end else begin
                    x_c     <= qx;
                    y_c     <= dq[YW-1:0];
                    c_valid <= 1'b1;
                end
            end

            if (vs_rise) begin
                div_s  <= m00;
                m01_s  <= m01;
                zero_s <= (m00 == '0);
                dq     <= m10;
                rem    <= '0;
                cnt    <= '0;
                state  <= (m00 == '0) ? UPDATE : DIV_X;
            end else begin
                case (state)
                    DIV_X: begin
                        dq  <= {dq[30:0], ge};
                        rem <= rem_nxt;
                        if (cnt == 6'd31) begin
                            cnt   <= '0;
                            state <= DIV_Y;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                    DIV_Y: begin
                        // First cycle banks the x quotient and loads the y dividend.
                        if (cnt == 6'd0) begin
                            qx  <= dq[XW-1:0];
                            dq  <= m01_s;
                            rem <= '0;
                            cnt <= 6'd1;
                        end else begin
                            dq  <= {dq[30:0], ge};
                            rem <= rem_nxt;
                            cnt <= cnt + 6'd1;
                            if (cnt == 6'd32)
                                state <= UPDATE;
                        end
                    end
                    UPDATE:  state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
